branch_pc_unit: RTL and testbench

Program-counter and branch-resolution stage that sits directly downstream of the ALU in the execute stage.
- Consumes the ALU flags (zeroFlag, lessThanFlag, greaterThanFlag) alongside a decoded branch request.
- Decides taken/not-taken and holds the architectural PC.
- Redirects fetch and drives a one-cycle flush of the wrong-path instruction.
- Small FSM handles the post-reset start, redirect bubble and halt.

---
 rtl/branch_pkg.sv | 28 ++
 rtl/branch_cond_eval.sv | 29 ++
 rtl/branch_pc_unit.sv | 131 +++++++++++++
 tb/tb_branch_pc_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch/PC stage: branch type codes, FSM state
// encoding and the default sequential PC step.
package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGT  = 3'b100;
  localparam logic [2:0] BR_JMP  = 3'b101;
  localparam logic [2:0] BR_HALT = 3'b110;
  localparam logic [2:0] BR_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_REDIRECT = 2'b10,
    ST_HALTED   = 2'b11
  } state_t;

  localparam int unsigned PC_STEP_DEF = 32'd4;

  // Fetch addresses are word aligned; the low two target bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational taken/not-taken decision from the branch type and ALU flags.
// HALT is not a taken branch here; the top handles it separately.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zeroFlag,
  input  logic       lessThanFlag,
  input  logic       greaterThanFlag,
  output logic       take
);

  // Each conditional type follows only its own flag; no arbitration between flags.
  always_comb begin
    take = 1'b0;
    case (br_type)
      BR_NONE: take = 1'b0;
      BR_BEQ:  take = zeroFlag;
      BR_BNE:  take = ~zeroFlag;
      BR_BLT:  take = lessThanFlag;
      BR_BGT:  take = greaterThanFlag;
      BR_JMP:  take = 1'b1;
      BR_HALT: take = 1'b0;
      BR_RSVD: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Execute-stage PC and branch resolution: holds the architectural PC, redirects
// fetch on taken branches with a one-cycle flush bubble, and handles halt.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = PC_STEP_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic [31:0]      br_target,
  input  logic             zeroFlag,
  input  logic             lessThanFlag,
  input  logic             greaterThanFlag,
  output logic [31:0]      pc_out,
  output logic             pc_valid,
  output logic             flush_out,
  output logic             br_taken_out,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_count
);

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        pc_nxt;
  logic               valid_nxt;
  logic               flush_nxt;
  logic               taken_nxt;
  logic               halted_nxt;
  logic               misalign_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               cond_take;
  logic               req_halt;
  logic               req_taken;

  branch_cond_eval u_cond (
    .br_type         (br_type),
    .zeroFlag        (zeroFlag),
    .lessThanFlag    (lessThanFlag),
    .greaterThanFlag (greaterThanFlag),
    .take            (cond_take)
  );

  assign req_halt  = br_valid & (br_type == BR_HALT);
  assign req_taken = br_valid & cond_take;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_out;
    valid_nxt    = 1'b0;
    flush_nxt    = 1'b0;
    taken_nxt    = 1'b0;
    halted_nxt   = halted;
    misalign_nxt = misalign_err;
    count_nxt    = taken_count;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_RUN;
        valid_nxt = 1'b1;
      end
      ST_RUN: begin
        if (req_halt) begin
          state_nxt  = ST_HALTED;
          halted_nxt = 1'b1;
          flush_nxt  = 1'b1;
        end else if (req_taken) begin
          // A resolved branch wins over both the stall and the increment.
          state_nxt    = ST_REDIRECT;
          pc_nxt       = word_align(br_target);
          flush_nxt    = 1'b1;
          taken_nxt    = 1'b1;
          misalign_nxt = misalign_err | (br_target[1:0] != 2'b00);
          if (&taken_count) begin
            count_nxt = taken_count;
          end else begin
            count_nxt = taken_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          valid_nxt = 1'b1;
          if (stall_in) begin
            pc_nxt = pc_out;
          end else begin
            pc_nxt = pc_out + 32'(PC_STEP);
          end
        end
      end
      ST_REDIRECT: begin
        // The request seen here belongs to the squashed instruction.
        state_nxt = ST_RUN;
        valid_nxt = 1'b1;
      end
      ST_HALTED: begin
        state_nxt  = ST_HALTED;
        halted_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc_out       <= RESET_PC;
      pc_valid     <= 1'b0;
      flush_out    <= 1'b0;
      br_taken_out <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      taken_count  <= {CNT_W{1'b0}};
    end else begin
      state        <= state_nxt;
      pc_out       <= pc_nxt;
      pc_valid     <= valid_nxt;
      flush_out    <= flush_nxt;
      br_taken_out <= taken_nxt;
      halted       <= halted_nxt;
      misalign_err <= misalign_nxt;
      taken_count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus a randomized
// run, all compared against a behavioural model of the stage.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        br_valid;
  logic [2:0]  br_type;
  logic [31:0] br_target;
  logic        zeroFlag;
  logic        lessThanFlag;
  logic        greaterThanFlag;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        flush_out;
  logic        br_taken_out;
  logic        halted;
  logic        misalign_err;
  logic [15:0] taken_count;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: "started" = first cycle after reset has passed,
  // "bubble" = the cycle after a redirect still has to be skipped.
  logic        m_started, m_bubble, m_halted, m_valid, m_flush, m_taken, m_mis;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic [52:0] act, exp;

  branch_pc_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_in        (stall_in),
    .br_valid        (br_valid),
    .br_type         (br_type),
    .br_target       (br_target),
    .zeroFlag        (zeroFlag),
    .lessThanFlag    (lessThanFlag),
    .greaterThanFlag (greaterThanFlag),
    .pc_out          (pc_out),
    .pc_valid        (pc_valid),
    .flush_out       (flush_out),
    .br_taken_out    (br_taken_out),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .taken_count     (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    logic takes;
    takes = br_valid && ((br_type == 3'd1 && zeroFlag) || (br_type == 3'd2 && !zeroFlag) ||
                         (br_type == 3'd3 && lessThanFlag) || (br_type == 3'd4 && greaterThanFlag) ||
                         (br_type == 3'd5));
    m_flush = 1'b0;
    m_taken = 1'b0;
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0; m_cnt = 16'd0;
      m_started = 1'b0; m_bubble = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (!m_started || m_bubble) begin
      m_started = 1'b1; m_bubble = 1'b0; m_valid = 1'b1;
    end else if (br_valid && br_type == 3'd6) begin
      m_halted = 1'b1; m_valid = 1'b0; m_flush = 1'b1;
    end else if (takes) begin
      m_pc = br_target & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_flush = 1'b1; m_taken = 1'b1; m_bubble = 1'b1;
      if (br_target % 4 != 0) m_mis = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_valid = 1'b1;
      if (!stall_in) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    act = {pc_out, pc_valid, flush_out, br_taken_out, halted, misalign_err, taken_count};
    exp = {m_pc, m_valid, m_flush, m_taken, m_halted, m_mis, m_cnt};
  endtask

  task automatic idle_inputs();
    stall_in = 1'b0; br_valid = 1'b0; br_type = 3'd0; br_target = 32'h0;
    zeroFlag = 1'b0; lessThanFlag = 1'b0; greaterThanFlag = 1'b0;
  endtask

  // Reset, release, and step into RUN with pc_out = 0.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0; cycle(); cycle();
    rst_n = 1'b1; cycle();
  endtask

  task automatic test_reset();
    do_reset();
    br_valid = 1'b1; br_type = 3'd5; br_target = 32'h33;
    cycle();
    br_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    n_checks++;
    if (act !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL reset_mid_redirect: got %h expected %h", act, {32'h0, 5'b0, 16'd0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    idle_inputs();
    rst_n = 1'b0; cycle();
    n_checks++;
    if (pc_valid !== 1'b0 || pc_out !== 32'h0) begin
      n_errors++;
      $display("FAIL idle_cycle: got pc %h valid %b expected pc 0 valid 0", pc_out, pc_valid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (pc_out !== 32'(4 * i) || pc_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL seq_pc[%0d]: got %h/%b expected %h/1", i, pc_out, pc_valid, 32'(4 * i));
      end
    end
  endtask

  task automatic test_beq_taken();
    do_reset(); cycle(); cycle();
    br_valid = 1'b1; br_type = 3'd1; zeroFlag = 1'b1; br_target = 32'h100;
    cycle();
    n_checks++;
    if (act !== {32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1}) begin
      n_errors++;
      $display("FAIL beq_redirect: got %h expected %h", act, {32'h100, 5'b01100, 16'd1});
    end
    idle_inputs();
    cycle();
    n_checks++;
    if (act !== {32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1}) begin
      n_errors++;
      $display("FAIL beq_resume: got %h expected %h", act, {32'h100, 5'b10000, 16'd1});
    end
    cycle();
    n_checks++;
    if (pc_out !== 32'h104 || pc_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL beq_step: got %h expected 00000104", pc_out);
    end
  endtask

  task automatic test_blt_not_taken();
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    br_valid = 1'b1; br_type = 3'd3; lessThanFlag = 1'b0; greaterThanFlag = 1'b1;
    br_target = 32'h800;
    cycle();
    n_checks++;
    if (act !== {32'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL blt_not_taken: got %h expected %h", act, {32'd20, 5'b10000, 16'd0});
    end
    idle_inputs();
  endtask

  task automatic test_stall_jmp();
    do_reset();
    for (int i = 0; i < 16; i++) cycle();
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (pc_out !== 32'h40 || pc_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got %h expected 00000040", i, pc_out);
      end
    end
    br_valid = 1'b1; br_type = 3'd5; br_target = 32'h203;
    cycle();
    n_checks++;
    if (act !== {32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1}) begin
      n_errors++;
      $display("FAIL stall_jmp_misalign: got %h expected %h", act, {32'h200, 5'b01101, 16'd1});
    end
    idle_inputs();
  endtask

  task automatic test_redirect_ignore_and_wrap();
    do_reset();
    br_valid = 1'b1; br_type = 3'd5; br_target = 32'hFFFF_FFF8;
    cycle();
    br_target = 32'h500;
    cycle();
    n_checks++;
    if (act !== {32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1}) begin
      n_errors++;
      $display("FAIL redirect_ignore: got %h expected %h", act, {32'hFFFF_FFF8, 5'b10000, 16'd1});
    end
    idle_inputs();
    cycle();
    n_checks++;
    if (pc_out !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_pre: got %h expected fffffffc", pc_out);
    end
    cycle();
    n_checks++;
    if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_zero: got %h/%b expected 00000000/1", pc_out, pc_valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 9; i++) cycle();
    br_valid = 1'b1; br_type = 3'd6;
    cycle();
    n_checks++;
    if (act !== {32'h24, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      n_errors++;
      $display("FAIL halt_enter: got %h expected %h", act, {32'h24, 5'b01010, 16'd0});
    end
    br_type = 3'd5;
    for (int i = 0; i < 10; i++) begin
      br_target = $urandom;
      stall_in = 1'($urandom);
      cycle();
      n_checks++;
      if (act !== {32'h24, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
        n_errors++;
        $display("FAIL halt_hold[%0d]: got %h expected %h", i, act, {32'h24, 5'b00010, 16'd0});
      end
    end
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    n_checks++;
    if (pc_out !== 32'h0 || halted !== 1'b0 || pc_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_reset: got pc %h halted %b expected pc 0 halted 0", pc_out, halted);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0] t;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      stall_in = ($urandom_range(0, 3) == 0);
      br_valid = 1'($urandom);
      t = 3'($urandom);
      if (t == 3'd6 && $urandom_range(0, 15) != 0) t = 3'd5;
      br_type = t;
      br_target = $urandom;
      if ($urandom_range(0, 1) == 0) br_target[1:0] = 2'b00;
      zeroFlag = 1'($urandom);
      lessThanFlag = 1'($urandom);
      greaterThanFlag = 1'($urandom);
      cycle();
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, act, exp);
      end
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_taken = 1'b0;
    m_halted = 1'b0; m_mis = 1'b0; m_cnt = 16'd0; m_started = 1'b0; m_bubble = 1'b0;
    #2;
    test_reset();
    test_sequential();
    test_beq_taken();
    test_blt_not_taken();
    test_stall_jmp();
    test_redirect_ignore_and_wrap();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
